parallel_to_serial_wrapper: RTL and testbench
=============================================

PARALLEL_TO_SERIAL_WRAPPER -- requirements
Module: parallel_to_serial_wrapper

Interface
REQ-001 Parameter WIDTH, default 4: bits per frame.
REQ-002 Parameter SIZE, default 8: maximum frames per transfer; parallel width is WIDTH*SIZE (32 by default).
REQ-003 Clock  input  1  rising-edge clock; the only clock.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Enable  input  1  arms the block; a transfer can start only while high.
REQ-006 load_send  input  1  start request, level-sensitive.
REQ-007 framesize  input  8  number of WIDTH-bit frames to send.
REQ-008 parallel  input  WIDTH*SIZE  data word to serialize.
REQ-009 serial  output  1  serial data line, MSB first.
REQ-010 complete  output  1  transfer-finished flag.

Function
REQ-011 The block SHALL implement three states: IDLE, SEND and DONE.
REQ-012 IDLE: serial SHALL be 1 and complete SHALL be 0.
REQ-013 IDLE->SEND SHALL occur on a rising edge where Enable=1 and load_send=1.
REQ-014 At that edge the block SHALL:
- latch parallel into a shift register;
- latch N = min(framesize, SIZE) and load the bit counter with N*WIDTH.
REQ-015 If the latched N=0, IDLE SHALL go directly to DONE, with no data bits sent.
REQ-016 SEND: serial SHALL present latched bits [N*WIDTH-1] down to [0], one bit per clock, MSB first.
- The first bit is valid in the cycle after the load edge.
- Bits above N*WIDTH-1 are never sent.
REQ-017 Once started, SEND SHALL run to completion regardless of Enable, load_send or parallel changes.
REQ-018 SEND->DONE SHALL occur on the edge that ends the last bit period.
REQ-019 DONE: complete SHALL be 1 and serial SHALL be 1.
REQ-020 DONE->IDLE SHALL occur on the first edge where load_send=0; while load_send stays 1 the block holds DONE, so one request gives exactly one transfer.
REQ-021 With Enable=0 in IDLE, load_send SHALL be ignored.
REQ-022 Bit counter width SHALL cover WIDTH*SIZE without overflow; the down-count SHALL never wrap.
REQ-023 Outputs SHALL be registered, with no combinational path from inputs to serial or complete.

Reset
REQ-024 Reset=0 SHALL immediately (asynchronously) force:
- state IDLE, serial=1, complete=0;
- shift register and counter cleared.
REQ-025 Reset asserted mid-SEND SHALL abort the transfer; after release, no resumption occurs and a new load_send is required.

Verification
REQ-026 WIDTH=4, SIZE=8, Enable=1, framesize=4, parallel=32'h0000_A5C3, load_send high for 1 cycle -> serial = 1010 0101 1100 0011 over 16 cycles, then complete=1; complete returns to 0 on the first cycle after load_send is low.
REQ-027 Same as REQ-026 but load_send held high for 20 cycles and Enable dropped right after the load edge -> one 16-bit transfer only; complete stays 1 until load_send falls.
REQ-028 Enable=0, load_send=1 for 10 cycles -> serial stays 1, complete stays 0.
REQ-029 framesize=0 -> serial stays 1; complete=1 on the cycle after the load edge.
REQ-030 framesize=200 with parallel=32'h8000_0001 -> clamped to 32 bits: serial 1, then 30 zeros, then 1; then complete=1.
REQ-031 Reset pulse after bit 5 of a 16-bit transfer -> serial=1 and complete=0 immediately; no further bits until a new load_send.

Source files
------------

// File: rtl/parallel_to_serial_wrapper.sv
// Serializes up to SIZE frames of WIDTH bits each, MSB first, then raises complete.
// One start request yields exactly one transfer; a new request needs load_send to fall first.
module parallel_to_serial_wrapper #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    load_send_i,
    input  logic [7:0]              framesize_i,
    input  logic [WIDTH*SIZE-1:0]   parallel_i,
    output logic                    serial_o,
    output logic                    complete_o
);
    localparam int PW = WIDTH * SIZE;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   shift_q;
    logic [CW-1:0]   cnt_q;
    logic            serial_q;
    logic            complete_q;

    logic [31:0]     frames_d;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   shift_d;
    logic [PW-1:0]   shift_nx;

    // The latched word is left-aligned so the first bit to send always sits in the MSB.
    always_comb begin
        frames_d = ({24'd0, framesize_i} > 32'(SIZE)) ? 32'(SIZE) : {24'd0, framesize_i};
        cnt_d    = CW'(frames_d * 32'(WIDTH));
        shift_d  = parallel_i << (32'(PW) - frames_d * 32'(WIDTH));
        shift_nx = shift_q << 1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            serial_q   <= 1'b1;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    serial_q   <= 1'b1;
                    complete_q <= 1'b0;
                    if (enable_i && load_send_i) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                        if (cnt_d == '0) begin
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                        end else begin
                            state_q  <= SEND;
                            serial_q <= shift_d[PW-1];
                        end
                    end
                end
                SEND: begin
                    // cnt_q counts bit periods still on the line, including the current one.
                    if (cnt_q <= CW'(1)) begin
                        state_q    <= DONE;
                        cnt_q      <= '0;
                        serial_q   <= 1'b1;
                        complete_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q - CW'(1);
                        shift_q  <= shift_nx;
                        serial_q <= shift_nx[PW-1];
                    end
                end
                DONE: begin
                    serial_q   <= 1'b1;
                    complete_q <= 1'b1;
                    if (!load_send_i) begin
                        state_q    <= IDLE;
                        complete_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    serial_q   <= 1'b1;
                    complete_q <= 1'b0;
                end
            endcase
        end
    end

    assign serial_o   = serial_q;
    assign complete_o = complete_q;
endmodule

// File: tb/tb_parallel_to_serial_wrapper.sv
// Scoreboard bench: expected serial bits are queued when a transfer is requested and
// popped as the serializer emits them; handshake and reset behaviour checked alongside.
module tb_parallel_to_serial_wrapper;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_send;
    logic [7:0]  framesize;
    logic [31:0] parallel;
    logic        serial;
    logic        complete;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    parallel_to_serial_wrapper #(.WIDTH(4), .SIZE(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .load_send_i (load_send),
        .framesize_i (framesize),
        .parallel_i  (parallel),
        .serial_o    (serial),
        .complete_o  (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one request; load_send stays high for 'hold' cycles counted from the load edge.
    task automatic xfer(input logic [7:0] fs, input logic [31:0] data, input int hold,
                        input bit drop_en);
        int n;
        int nb;
        int cyc;
        n  = (fs > 8) ? 8 : int'(fs);
        nb = n * 4;
        for (int i = nb - 1; i >= 0; i--) exp_q.push_back(data[i]);
        @(negedge clk);
        enable    = 1'b1;
        load_send = 1'b1;
        framesize = fs;
        parallel  = data;
        @(posedge clk);
        #1;
        if (drop_en) enable = 1'b0;
        parallel  = $urandom;
        framesize = 8'($urandom);
        cyc = 1;
        if (cyc >= hold) load_send = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_eq("serial_bit", 32'(serial), 32'(exp_q.pop_front()));
            check_eq("complete_busy", 32'(complete), 32'd0);
            cyc++;
            if (cyc >= hold) load_send = 1'b0;
        end
        @(negedge clk);
        check_eq("complete_done", 32'(complete), 32'd1);
        check_eq("serial_done", 32'(serial), 32'd1);
        cyc++;
        while (load_send) begin
            if (cyc >= hold) begin
                load_send = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
                check_eq("complete_hold", 32'(complete), 32'd1);
                check_eq("serial_hold", 32'(serial), 32'd1);
            end
        end
        @(negedge clk);
        check_eq("complete_idle", 32'(complete), 32'd0);
        check_eq("serial_idle", 32'(serial), 32'd1);
        $display("xfer fs=%0d data=%08h hold=%0d drop_en=%0d bits=%0d", fs, data, hold, drop_en, nb);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        load_send = 1'b0;
        framesize = 8'd0;
        parallel  = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_serial", 32'(serial), 32'd1);
        check_eq("reset_complete", 32'(complete), 32'd0);
        rst_n = 1'b1;
        $display("reset released");

        xfer(8'd4, 32'h0000_A5C3, 1, 1'b0);
        xfer(8'd4, 32'h0000_A5C3, 20, 1'b1);

        // Disabled: requests must be ignored.
        @(negedge clk);
        enable    = 1'b0;
        load_send = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("dis_serial", 32'(serial), 32'd1);
            check_eq("dis_complete", 32'(complete), 32'd0);
        end
        load_send = 1'b0;
        $display("disabled request held 10 cycles");

        xfer(8'd0, 32'hFFFF_FFFF, 1, 1'b0);
        xfer(8'd200, 32'h8000_0001, 1, 1'b0);
        xfer(8'd1, 32'h0000_000A, 1, 1'b0);
        xfer(8'd8, 32'h1234_5678, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            xfer(8'($urandom_range(1, 9)), $urandom, $urandom_range(1, 40), 1'($urandom));
        end

        // Abort after five bits of a 16-bit transfer.
        @(negedge clk);
        enable    = 1'b1;
        load_send = 1'b1;
        framesize = 8'd4;
        parallel  = 32'h0000_A5C3;
        @(posedge clk);
        #1;
        load_send = 1'b0;
        for (int i = 15; i >= 11; i--) begin
            @(negedge clk);
            check_eq("pre_abort_bit", 32'(serial), 32'(parallel[i] & 1'b0) | 32'((32'h0000_A5C3 >> i) & 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_serial", 32'(serial), 32'd1);
        check_eq("abort_complete", 32'(complete), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("post_abort_serial", 32'(serial), 32'd1);
            check_eq("post_abort_complete", 32'(complete), 32'd0);
        end
        $display("reset abort after 5 bits");

        xfer(8'd4, 32'h0000_3C96, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
